// File: rtl/bus_arbiter_if.sv
// Requester/memory bundle for bus_arbiter: two requester ports plus the shared RAM port.
// master = requesters and RAM side, slave = the arbiter.
interface bus_arbiter_if #(
    parameter int ADDR_W = 30
);
    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic [31:0]       m0_data_w;
    logic [3:0]        m0_mask_w;
    logic              m0_lock;
    logic              m0_ack;
    logic [31:0]       m0_data_r;

    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic [31:0]       m1_data_w;
    logic [3:0]        m1_mask_w;
    logic              m1_lock;
    logic              m1_ack;
    logic [31:0]       m1_data_r;

    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_data_w;
    logic [3:0]        bus_mask_w;
    logic [31:0]       bus_data_r;

    modport master (
        output m0_req, m0_addr, m0_data_w, m0_mask_w, m0_lock,
        input  m0_ack, m0_data_r,
        output m1_req, m1_addr, m1_data_w, m1_mask_w, m1_lock,
        input  m1_ack, m1_data_r,
        input  bus_addr, bus_data_w, bus_mask_w,
        output bus_data_r
    );

    modport slave (
        input  m0_req, m0_addr, m0_data_w, m0_mask_w, m0_lock,
        output m0_ack, m0_data_r,
        input  m1_req, m1_addr, m1_data_w, m1_mask_w, m1_lock,
        output m1_ack, m1_data_r,
        output bus_addr, bus_data_w, bus_mask_w,
        input  bus_data_r
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one word-addressed RAM port between two requesters (IDLE/ACCESS/RESP).
// Define BUS_ARBITER_LOCK_EN to compile in bus locking; otherwise mN_lock is ignored.
module bus_arbiter #(
    parameter int ADDR_W = 30
) (
    input logic          clock,
    input logic          reset,
    bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_start;
    logic              w_req0;
    logic              w_req1;
    logic              w_grant;
    logic              r_winner;
    logic              r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_mask;
    logic [31:0]       r_data_r0;
    logic [31:0]       r_data_r1;

`ifdef BUS_ARBITER_LOCK_EN
    logic r_lock_valid;
    logic r_lock_owner;

    // While locked, the non-owner's request is masked out of arbitration.
    assign w_req0 = bus.m0_req & ~(r_lock_valid & r_lock_owner);
    assign w_req1 = bus.m1_req & ~(r_lock_valid & ~r_lock_owner);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lock_valid <= 1'b0;
            r_lock_owner <= 1'b0;
        end else if (r_state == ACCESS) begin
            r_lock_valid <= r_winner ? bus.m1_lock : bus.m0_lock;
            r_lock_owner <= r_winner;
        end
    end
`else
    logic w_unused_lock;

    assign w_req0        = bus.m0_req;
    assign w_req1        = bus.m1_req;
    assign w_unused_lock = bus.m0_lock | bus.m1_lock;
`endif

    // Contention goes to the requester not granted last; a lone requester always wins.
    assign w_grant = (w_req0 & w_req1) ? ~r_last : w_req1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        w_start        = 1'b0;
        bus.bus_mask_w = '0;
        bus.m0_ack     = 1'b0;
        bus.m1_ack     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req0 | w_req1) begin
                    w_start = 1'b1;
                    w_next  = ACCESS;
                end
            end
            ACCESS: begin
                bus.bus_mask_w = r_mask;
                w_next         = RESP;
            end
            RESP: begin
                bus.m0_ack = ~r_winner;
                bus.m1_ack = r_winner;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_winner  <= 1'b0;
            r_last    <= 1'b1;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_mask    <= '0;
            r_data_r0 <= '0;
            r_data_r1 <= '0;
        end else begin
            if (w_start) begin
                r_winner <= w_grant;
                r_addr   <= w_grant ? bus.m1_addr   : bus.m0_addr;
                r_wdata  <= w_grant ? bus.m1_data_w : bus.m0_data_w;
                r_mask   <= w_grant ? bus.m1_mask_w : bus.m0_mask_w;
            end
            if (r_state == ACCESS) begin
                if (r_winner) r_data_r1 <= bus.bus_data_r;
                else          r_data_r0 <= bus.bus_data_r;
            end
            if (r_state == RESP) r_last <= r_winner;
        end
    end

    assign bus.bus_addr   = r_addr;
    assign bus.bus_data_w = r_wdata;
    assign bus.m0_data_r  = r_data_r0;
    assign bus.m1_data_r  = r_data_r1;
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed transactions push expected acks; a negedge monitor checks them.
`timescale 1ns/1ps
module tb_bus_arbiter;
    localparam int ADDR_W = 30;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bus_arbiter_if #(.ADDR_W(ADDR_W)) bif ();
    bus_arbiter #(.ADDR_W(ADDR_W)) dut (.clock(clock), .reset(reset), .bus(bif.slave));

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          mask_cycles = 0;
    logic [3:0]  last_mask = '0;
    logic        prev_mask_nz = 1'b0;
    logic        prev_ack0 = 1'b0;
    logic        prev_ack1 = 1'b0;
    logic [31:0] mem [0:255];
    int          c0, c1, t_rel, got;
    int          t0a[2];
    int          t1a[2];

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // RAM samples on the falling edge: read returns the pre-write word.
    always @(negedge clock) begin
        bif.bus_data_r = mem[bif.bus_addr[7:0]];
        for (int b = 0; b < 4; b++)
            if (bif.bus_mask_w[b]) mem[bif.bus_addr[7:0]][8*b +: 8] = bif.bus_data_w[8*b +: 8];
    end

    always @(negedge clock) begin
        check("ack_exclusive", {31'b0, bif.m0_ack & bif.m1_ack}, 32'd0);
        check("m0_ack_single", {31'b0, prev_ack0 & bif.m0_ack}, 32'd0);
        check("m1_ack_single", {31'b0, prev_ack1 & bif.m1_ack}, 32'd0);
        check("mask_single_cycle", {31'b0, prev_mask_nz & (|bif.bus_mask_w)}, 32'd0);
        check("mask_zero_in_resp", {31'b0, (bif.m0_ack | bif.m1_ack) & (|bif.bus_mask_w)}, 32'd0);
        if (|bif.bus_mask_w) begin
            mask_cycles++;
            last_mask = bif.bus_mask_w;
        end
        if (bif.m0_ack || bif.m1_ack) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ack: m0_ack=%b m1_ack=%b, expected none (cycle %0d)",
                         bif.m0_ack, bif.m1_ack, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("ack_id", {31'b0, bif.m1_ack}, {31'b0, mon_e.id});
                check("data_r", mon_e.id ? bif.m1_data_r : bif.m0_data_r, mon_e.data);
            end
        end
        prev_mask_nz = |bif.bus_mask_w;
        prev_ack0    = bif.m0_ack;
        prev_ack1    = bif.m1_ack;
    end

    task automatic drive(input int n, input logic r, input logic [ADDR_W-1:0] a,
                         input logic [31:0] d, input logic [3:0] m, input logic lk);
        if (n == 0) begin
            bif.m0_req = r; bif.m0_addr = a; bif.m0_data_w = d; bif.m0_mask_w = m; bif.m0_lock = lk;
        end else begin
            bif.m1_req = r; bif.m1_addr = a; bif.m1_data_w = d; bif.m1_mask_w = m; bif.m1_lock = lk;
        end
    endtask

    task automatic do_txn(input int n, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                          input logic [3:0] m, input logic lk, input bit chk_lat);
        int  t0;
        bit  ack;
        @(negedge clock);
        drive(n, 1'b1, a, d, m, lk);
        t0  = cyc;
        ack = 1'b0;
        for (int w = 0; w < 30 && !ack; w++) begin
            @(negedge clock);
            ack = (n == 0) ? bif.m0_ack : bif.m1_ack;
        end
        if (!ack) begin
            n_vec++;
            n_err++;
            $display("FAIL ack_timeout: m%0d got no ack, expected one within 30 cycles", n);
        end else if (chk_lat) begin
            check("ack_latency", 32'(cyc - t0), 32'd2);
        end
        drive(n, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic expect_ack(input logic id, input logic [31:0] data);
        sb_q.push_back('{id: id, data: data});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h20] = 32'h1111_1111;
        mem[8'h21] = 32'h2222_2222;
        mem[8'h22] = 32'h3333_3333;
        drive(0, 1'b0, '0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, '0, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        check("rst_bus_addr", 32'(bif.bus_addr), 32'd0);
        check("rst_bus_data_w", bif.bus_data_w, 32'd0);
        check("rst_bus_mask_w", {28'b0, bif.bus_mask_w}, 32'd0);
        check("rst_m0_ack", {31'b0, bif.m0_ack}, 32'd0);
        check("rst_m1_ack", {31'b0, bif.m1_ack}, 32'd0);
        check("rst_m0_data_r", bif.m0_data_r, 32'd0);
        check("rst_m1_data_r", bif.m1_data_r, 32'd0);
        reset = 1'b1;

        // Full-word write, read back, byte write from m1, read back.
        mask_cycles = 0;
        expect_ack(1'b0, 32'h0000_0000);
        do_txn(0, 'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1);
        check("write_mask_cycles", 32'(mask_cycles), 32'd1);
        check("write_mask_value", {28'b0, last_mask}, 32'hF);
        expect_ack(1'b0, 32'hDEAD_BEEF);
        do_txn(0, 'h10, 32'h0, 4'h0, 1'b0, 1'b1);
        check("read_no_mask", 32'(mask_cycles), 32'd1);
        expect_ack(1'b1, 32'hDEAD_BEEF);
        do_txn(1, 'h10, 32'h0000_00AA, 4'h1, 1'b0, 1'b1);
        expect_ack(1'b1, 32'hDEAD_BEAA);
        do_txn(1, 'h10, 32'h0, 4'h0, 1'b0, 1'b1);
        check("m0_data_r_held", bif.m0_data_r, 32'hDEAD_BEEF);

        // Both requesting from reset release, held: grants alternate 0,1,0,1.
        @(negedge clock);
        reset = 1'b0;
        expect_ack(1'b0, 32'h1111_1111);
        expect_ack(1'b1, 32'h3333_3333);
        expect_ack(1'b0, 32'h1111_1111);
        expect_ack(1'b1, 32'h3333_3333);
        drive(0, 1'b1, 'h20, '0, '0, 1'b0);
        drive(1, 1'b1, 'h22, '0, '0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        t_rel = cyc;
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 40 && (c0 < 2 || c1 < 2); i++) begin
            @(negedge clock);
            if (bif.m0_ack && c0 < 2) begin
                t0a[c0] = cyc; c0++;
                if (c0 == 2) bif.m0_req = 1'b0;
            end
            if (bif.m1_ack && c1 < 2) begin
                t1a[c1] = cyc; c1++;
                if (c1 == 2) bif.m1_req = 1'b0;
            end
        end
        check("rr_m0_acks", 32'(c0), 32'd2);
        check("rr_m1_acks", 32'(c1), 32'd2);
        if (c0 == 2 && c1 == 2) begin
            check("rr_first_latency", 32'(t0a[0] - t_rel), 32'd2);
            check("rr_m0_period", 32'(t0a[1] - t0a[0]), 32'd6);
            check("rr_m1_period", 32'(t1a[1] - t1a[0]), 32'd6);
            check("rr_m1_offset", 32'(t1a[0] - t0a[0]), 32'd3);
        end
        drive(1, 1'b0, '0, '0, '0, 1'b0);

        // Reset in the middle of an m0 write while m1 waits.
        @(negedge clock);
        drive(0, 1'b1, 'h30, 32'h1234_5678, 4'hF, 1'b0);
        drive(1, 1'b1, 'h10, '0, '0, 1'b0);
        @(posedge clock);
        #1;
        check("midacc_mask", {28'b0, bif.bus_mask_w}, 32'hF);
        reset = 1'b0;
        #1;
        check("midacc_bus_mask_w", {28'b0, bif.bus_mask_w}, 32'd0);
        check("midacc_bus_addr", 32'(bif.bus_addr), 32'd0);
        check("midacc_bus_data_w", bif.bus_data_w, 32'd0);
        check("midacc_m0_ack", {31'b0, bif.m0_ack}, 32'd0);
        check("midacc_m1_ack", {31'b0, bif.m1_ack}, 32'd0);
        check("midacc_m0_data_r", bif.m0_data_r, 32'd0);
        check("midacc_m1_data_r", bif.m1_data_r, 32'd0);
        bif.m0_req = 1'b0;
        @(negedge clock);
        check("midacc_no_write", mem[8'h30], 32'd0);
        expect_ack(1'b1, 32'hDEAD_BEAA);
        reset = 1'b1;
        t_rel = cyc;
        got   = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clock);
            if (bif.m1_ack) got = 1;
        end
        check("post_reset_m1_served", 32'(got), 32'd1);
        check("post_reset_latency", 32'(cyc - t_rel), 32'd2);
        drive(1, 1'b0, '0, '0, '0, 1'b0);

        // m0 three reads with lock 1,1,0 against a waiting m1.
`ifdef BUS_ARBITER_LOCK_EN
        expect_ack(1'b0, 32'h1111_1111);
        expect_ack(1'b0, 32'h2222_2222);
        expect_ack(1'b0, 32'h1111_1111);
        expect_ack(1'b1, 32'h3333_3333);
`else
        expect_ack(1'b0, 32'h1111_1111);
        expect_ack(1'b1, 32'h3333_3333);
        expect_ack(1'b0, 32'h2222_2222);
        expect_ack(1'b0, 32'h1111_1111);
`endif
        fork
            begin
                do_txn(0, 'h20, '0, '0, 1'b1, 1'b0);
                do_txn(0, 'h21, '0, '0, 1'b1, 1'b0);
                do_txn(0, 'h20, '0, '0, 1'b0, 1'b0);
            end
            do_txn(1, 'h22, '0, '0, 1'b0, 1'b0);
        join
        repeat (4) @(negedge clock);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
